iir_coeff_loader: RTL

IIR_COEFF_LOADER -- requirements
Module: iir_coeff_loader

---
 rtl/iir_coeff_loader_pkg.sv | 23 ++
 rtl/iir_coeff_loader_if.sv | 18 +
 rtl/iir_coeff_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/iir_coeff_loader_pkg.sv
// ====================================================================
// iir_coeff_loader_pkg - FSM encoding and unity-coefficient helper. Rev 1.0
// ====================================================================
`default_nettype none

package iir_coeff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  // Wide result; callers narrow it to their coefficient width.
  function automatic logic [63:0] unity_coeff(input int unsigned q);
    return 64'd1 << q;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iir_coeff_loader_if.sv
// ====================================================================
// iir_coeff_loader_if - valid/ready coefficient word stream. Rev 1.0
// ====================================================================
`default_nettype none

interface iir_coeff_loader_if #(
  parameter int COEFF_WIDTH = 16
);
  logic                   coeff_valid;
  logic                   coeff_ready;
  logic [COEFF_WIDTH-1:0] coeff_data;
  logic                   coeff_last;

  modport master (output coeff_valid, coeff_data, coeff_last, input coeff_ready);
  modport slave  (input coeff_valid, coeff_data, coeff_last, output coeff_ready);
endinterface

`default_nettype wire

// File: rtl/iir_coeff_loader.sv
// ====================================================================
// iir_coeff_loader - framed shadow load, single-cycle commit to active set. Rev 1.0
// ====================================================================
`default_nettype none

module iir_coeff_loader #(
  parameter int N           = 2,
  parameter int COEFF_WIDTH = 16,
  parameter int Q           = 14
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  iir_coeff_loader_if.slave            s_coeff,
  output logic [COEFF_WIDTH*(N+1)-1:0] packed_b_coeffs,
  output logic [COEFF_WIDTH*N-1:0]     packed_a_coeffs,
  output logic                         coeff_updated,
  output logic                         frame_error
);
  import iir_coeff_loader_pkg::*;

  localparam int c_words = 2*N + 1;
  localparam int c_cnt_w = $clog2(2*N + 2);
  typedef logic [c_cnt_w-1:0] cnt_t;
  localparam cnt_t c_last_idx = cnt_t'(c_words - 1);
  localparam cnt_t c_n        = cnt_t'(N);
  localparam logic [COEFF_WIDTH-1:0] c_unity = COEFF_WIDTH'(unity_coeff(Q));

  state_t r_state, w_state_nxt;
  cnt_t   r_cnt, w_cnt_nxt;
  logic   w_acc, w_wr_en, w_commit, w_ferr_set, w_ferr_clr;
  logic   r_frame_error;

  logic [COEFF_WIDTH-1:0] r_sh_b  [N+1];
  logic [COEFF_WIDTH-1:0] r_sh_a  [N];
  logic [COEFF_WIDTH-1:0] r_act_b [N+1];
  logic [COEFF_WIDTH-1:0] r_act_a [N];

  assign s_coeff.coeff_ready = (r_state != ST_COMMIT);
  assign w_acc               = s_coeff.coeff_valid && (r_state != ST_COMMIT);
  assign coeff_updated       = (r_state == ST_COMMIT);
  assign frame_error         = r_frame_error;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_ferr_set  = 1'b0;
    w_ferr_clr  = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD_B, ST_LOAD_A: begin
        if (w_acc) begin
          w_wr_en    = 1'b1;
          w_ferr_clr = (r_state == ST_IDLE);
          if (r_cnt == c_last_idx) begin
            w_cnt_nxt = '0;
            if (s_coeff.coeff_last) begin
              w_state_nxt = ST_COMMIT;
            end else begin
              w_state_nxt = ST_DRAIN;
              w_ferr_set  = 1'b1;
            end
          end else if (s_coeff.coeff_last) begin
            // Short frame: shadow contents are simply overwritten by the next frame.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_ferr_set  = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = (r_cnt < c_n) ? ST_LOAD_B : ST_LOAD_A;
          end
        end
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
      ST_DRAIN: begin
        if (w_acc && s_coeff.coeff_last) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= N; i++) begin
        r_sh_b[i]  <= (i == 0) ? c_unity : '0;
        r_act_b[i] <= (i == 0) ? c_unity : '0;
      end
      for (int i = 0; i < N; i++) begin
        r_sh_a[i]  <= '0;
        r_act_a[i] <= '0;
      end
      r_frame_error <= 1'b0;
    end else begin
      // Word index r_cnt maps to b0..bN, then a1..aN.
      for (int i = 0; i <= N; i++) begin
        if (w_wr_en && (r_cnt == cnt_t'(i))) r_sh_b[i] <= s_coeff.coeff_data;
      end
      for (int i = 0; i < N; i++) begin
        if (w_wr_en && (r_cnt == cnt_t'(N + 1 + i))) r_sh_a[i] <= s_coeff.coeff_data;
      end
      if (w_commit) begin
        r_act_b <= r_sh_b;
        r_act_a <= r_sh_a;
      end
      if (w_ferr_set)      r_frame_error <= 1'b1;
      else if (w_ferr_clr) r_frame_error <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi <= N; gi++) begin : g_pack_b
      assign packed_b_coeffs[gi*COEFF_WIDTH +: COEFF_WIDTH] = r_act_b[gi];
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_pack_a
      assign packed_a_coeffs[gi*COEFF_WIDTH +: COEFF_WIDTH] = r_act_a[gi];
    end
  endgenerate

endmodule

`default_nettype wire
